easy_cpu_cpu_mult_pipe: RTL and testbench

Parametrised two-stage pipelined integer multiplier for the easy_cpu execute/memory path. It replaces the fixed 16×16 partial-product cell with a complete DATA_W×DATA_W unit. It returns either the low word or the signed/unsigned high word of the 2·DATA_W-bit product, with a valid flag tracked through the pipeline. It sits between the E-stage operand muxes and the M/W-stage result mux and advances under the shared M_en pipeline enable.

---
 rtl/easy_cpu_cpu_mult_pipe.sv | 111 +++++++++++
 tb/tb_easy_cpu_cpu_mult_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/easy_cpu_cpu_mult_pipe.sv
// easy_cpu two-stage pipelined DATA_W x DATA_W multiplier for the E->M path.
// Ports:
//   clk, reset_n (sync, active-low)
//   E_src1/E_src2 operands, E_valid issue, E_mode product word select
//   M_en pipeline advance (0 freezes all state)
//   M_valid / M_result registered product word
// Option: `define MULT_FULL_PRODUCT_EN builds hh and the signed
// correction so the high-word modes work; otherwise only the low word
// is produced (three-multiplier footprint) and E_mode is ignored.
module easy_cpu_cpu_mult_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_valid,
  input  logic [1:0]        E_mode,
  input  logic              M_en,
  output logic              M_valid,
  output logic [DATA_W-1:0] M_result
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [DATA_W-1:0] ll_d, lh_d, hl_d;
  logic [DATA_W-1:0] s1_ll, s1_lh, s1_hl;
  logic              s1_valid;
  logic [DATA_W-1:0] res_d;

  assign a_lo = E_src1[HALF_W-1:0];
  assign a_hi = E_src1[DATA_W-1:HALF_W];
  assign b_lo = E_src2[HALF_W-1:0];
  assign b_hi = E_src2[DATA_W-1:HALF_W];

  // Zero-extend halves so each unsigned product is exact in DATA_W bits.
  assign ll_d = DATA_W'(a_lo) * DATA_W'(b_lo);
  assign lh_d = DATA_W'(a_lo) * DATA_W'(b_hi);
  assign hl_d = DATA_W'(a_hi) * DATA_W'(b_lo);

`ifdef MULT_FULL_PRODUCT_EN
  logic [DATA_W-1:0] hh_d, corr_d;
  logic [DATA_W-1:0] s1_hh, s1_corr;
  logic [1:0]        s1_mode;
  logic [PROD_W-1:0] prod;

  assign hh_d = DATA_W'(a_hi) * DATA_W'(b_hi);

  // Signed operands weigh their msb as -2^(W-1) instead of +2^(W-1):
  // subtracting the other operand from the high word fixes that up.
  always_comb begin
    corr_d = '0;
    if (E_mode[1] && E_src1[DATA_W-1])
      corr_d = E_src2;
    if (E_mode == 2'b11 && E_src2[DATA_W-1])
      corr_d = corr_d + E_src1;
  end

  always_comb begin
    prod = PROD_W'(s1_ll)
         + (PROD_W'(s1_lh) << HALF_W)
         + (PROD_W'(s1_hl) << HALF_W)
         + (PROD_W'(s1_hh) << DATA_W);
    case (s1_mode)
      2'b00:   res_d = prod[DATA_W-1:0];
      2'b01:   res_d = prod[PROD_W-1:DATA_W];
      default: res_d = prod[PROD_W-1:DATA_W] - s1_corr;
    endcase
  end
`else
  logic unused_mode;

  assign unused_mode = ^E_mode;

  // Only the low word is needed; hh never reaches it.
  always_comb begin
    res_d = s1_ll + (s1_lh << HALF_W) + (s1_hl << HALF_W);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_ll    <= '0;
      s1_lh    <= '0;
      s1_hl    <= '0;
`ifdef MULT_FULL_PRODUCT_EN
      s1_hh    <= '0;
      s1_corr  <= '0;
      s1_mode  <= 2'b00;
`endif
      M_valid  <= 1'b0;
      M_result <= '0;
    end else if (M_en) begin
      s1_valid <= E_valid;
      s1_ll    <= ll_d;
      s1_lh    <= lh_d;
      s1_hl    <= hl_d;
`ifdef MULT_FULL_PRODUCT_EN
      s1_hh    <= hh_d;
      s1_corr  <= corr_d;
      s1_mode  <= E_mode;
`endif
      M_valid  <= s1_valid;
      M_result <= res_d;
    end
  end

endmodule

// File: tb/tb_easy_cpu_cpu_mult_pipe.sv
// Self-checking bench for easy_cpu_cpu_mult_pipe (DATA_W=32).
// Directed table, hand sequences and random traffic against a model.
module tb_easy_cpu_cpu_mult_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] E_src1 = '0;
  logic [31:0] E_src2 = '0;
  logic        E_valid = 1'b0;
  logic [1:0]  E_mode = 2'b00;
  logic        M_en = 1'b0;
  logic        M_valid;
  logic [31:0] M_result;

  int n_vec = 0;
  int n_err = 0;

  // Model: what S1 holds (valid + eventual word) and what outputs hold.
  logic        mv1 = 1'b0, mv2 = 1'b0;
  logic [31:0] mr1 = '0, mr2 = '0;

  always #5 clk = ~clk;

  easy_cpu_cpu_mult_pipe #(.DATA_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .E_src1   (E_src1),
    .E_src2   (E_src2),
    .E_valid  (E_valid),
    .E_mode   (E_mode),
    .M_en     (M_en),
    .M_valid  (M_valid),
    .M_result (M_result)
  );

  function automatic logic [31:0] ref_mul(
    input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    longint unsigned ua, ub;
    longint          sa, sb;
    logic [63:0]     p;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = ua * ub;
`ifdef MULT_FULL_PRODUCT_EN
    case (m)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      default: begin p = 64'(sa * sb); return p[63:32]; end
    endcase
`else
    if (m == 2'b11 && sa == sb) return p[31:0];
    return p[31:0];
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Drive one cycle, update the model on the edge, compare #1 later.
  task automatic tick(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] m, input logic v,
                      input logic en, input logic rn);
    E_src1  = a;
    E_src2  = b;
    E_mode  = m;
    E_valid = v;
    M_en    = en;
    reset_n = rn;
    @(posedge clk);
    if (!rn) begin
      mv1 = 1'b0; mv2 = 1'b0; mr1 = '0; mr2 = '0;
    end else if (en) begin
      mv2 = mv1; mr2 = mr1;
      mv1 = v;   mr1 = ref_mul(a, b, m);
    end
    #1;
    chk("model_valid", 32'(M_valid), 32'(mv2));
    chk("model_result", M_result, mr2);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  m;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
`ifdef MULT_FULL_PRODUCT_EN
    tbl[0] = '{32'h0001_0003, 32'h0002_0005, 2'b00, 32'h000B_000F};
    tbl[1] = '{32'h0001_0003, 32'h0002_0005, 2'b01, 32'h0000_0002};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFE};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000};
    tbl[5] = '{32'h8000_0000, 32'h0000_0002, 2'b11, 32'hFFFF_FFFF};
    tbl[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000};
    tbl[7] = '{32'h0000_0007, 32'h0000_0006, 2'b00, 32'h0000_002A};
`else
    tbl[0] = '{32'h0001_0003, 32'h0002_0005, 2'b00, 32'h000B_000F};
    tbl[1] = '{32'h0001_0003, 32'h0002_0005, 2'b01, 32'h000B_000F};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0001};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h0000_0001};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0001};
    tbl[5] = '{32'h8000_0000, 32'h0000_0002, 2'b11, 32'h0000_0000};
    tbl[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000};
    tbl[7] = '{32'h0000_0007, 32'h0000_0006, 2'b00, 32'h0000_002A};
`endif

    @(negedge clk);
    tick('0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 1'b1, 1'b1, 1'b0);
    chk("reset_valid", 32'(M_valid), 32'd0);
    chk("reset_result", M_result, 32'd0);

    // Back-to-back issues; entry i emerges after issuing entry i+1.
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].a, tbl[i].b, tbl[i].m, 1'b1, 1'b1, 1'b1);
      if (i > 0) begin
        chk("tbl_valid", 32'(M_valid), 32'd1);
        chk("tbl_result", M_result, tbl[i-1].exp);
      end
    end
    tick('0, '0, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("tbl_last_valid", 32'(M_valid), 32'd1);
    chk("tbl_last_result", M_result, tbl[7].exp);
    tick('0, '0, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("tbl_drain_valid", 32'(M_valid), 32'd0);

    // Freeze: 7*6 issued, then M_en=0 with new operands.
    tick(32'd7, 32'd6, 2'b00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(32'd100 + 32'(i), 32'd55, 2'b01, 1'b1, 1'b0, 1'b1);
      chk("freeze_valid", 32'(M_valid), 32'd0);
    end
    tick(32'd9, 32'd9, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("freeze_out_valid", 32'(M_valid), 32'd1);
    chk("freeze_out_result", M_result, 32'h0000_002A);
    tick(32'd9, 32'd9, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(32'd9, 32'd9, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("hold_result", M_result, 32'h0000_002A);
    chk("hold_valid", 32'(M_valid), 32'd1);

    // Reset while a multiply is in flight.
    tick(32'd11, 32'd13, 2'b00, 1'b1, 1'b1, 1'b1);
    tick(32'd3, 32'd3, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("rst_fl_valid", 32'(M_valid), 32'd0);
    chk("rst_fl_result", M_result, 32'd0);
    tick(32'd3, 32'd3, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("rst_fl_never", 32'(M_valid), 32'd0);

    // Idle with nonzero operands.
    for (int i = 0; i < 4; i++) begin
      tick(32'hDEAD_0000 + 32'(i), 32'h0000_BEEF, 2'b00, 1'b0, 1'b1, 1'b1);
      chk("idle_valid", 32'(M_valid), 32'd0);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tick($urandom, $urandom, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 40) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
